// File: rtl/simd_lane_accum_if.sv
// Bundles the sample-side inputs and result-side outputs of the SIMD lane accumulator.
// Widths follow the same parameters as the accumulator so a single instance sizes both ends.
// The master drives operands and controls; the slave (the accumulator) drives results.
interface simd_lane_accum_if #(
  parameter int NLANES   = 4,
  parameter int WIDTH    = 12,
  parameter int ACC_BITS = 4
);
  localparam int OW = WIDTH + 1 + ACC_BITS;

  logic [NLANES*WIDTH-1:0] a_in;
  logic [NLANES*WIDTH-1:0] b_in;
  logic                    valid_in;
  logic                    mode;
  logic [ACC_BITS-1:0]     acc_len;
  logic                    flush;
  logic [NLANES*OW-1:0]    sum_out;
  logic [ACC_BITS:0]       cnt_out;
  logic                    valid_out;
  logic                    busy;

  modport master (
    output a_in, b_in, valid_in, mode, acc_len, flush,
    input  sum_out, cnt_out, valid_out, busy
  );

  modport slave (
    input  a_in, b_in, valid_in, mode, acc_len, flush,
    output sum_out, cnt_out, valid_out, busy
  );
endinterface

// File: rtl/simd_lane_accum.sv
// Per-lane unsigned pair adder with optional windowed accumulation of the pair sums.
// Latency 2+INPUT_REG cycles from the closing sample (or flush) to valid_out.
// No backpressure: accepts one sample per cycle continuously, windows may abut with no bubble.
module simd_lane_accum #(
  parameter int NLANES    = 4,
  parameter int WIDTH     = 12,
  parameter int ACC_BITS  = 4,
  parameter int INPUT_REG = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  simd_lane_accum_if.slave io_bus
);
  localparam int OW = WIDTH + 1 + ACC_BITS;
  localparam logic [ACC_BITS:0] CNT_ONE = (ACC_BITS+1)'(1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  // Stage 0 outputs (registered or straight from the bus)
  logic [NLANES*WIDTH-1:0] w_s0_a;
  logic [NLANES*WIDTH-1:0] w_s0_b;
  logic                    w_s0_vld;
  logic                    w_s0_mode;
  logic [ACC_BITS-1:0]     w_s0_len;
  logic                    w_s0_flush;

  generate
    if (INPUT_REG != 0) begin : g_in_reg
      logic [NLANES*WIDTH-1:0] r_a;
      logic [NLANES*WIDTH-1:0] r_b;
      logic                    r_vld;
      logic                    r_mode;
      logic [ACC_BITS-1:0]     r_len;
      logic                    r_flush;

      // Optional input register: eases timing into the lane adders.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_a     <= '0;
          r_b     <= '0;
          r_vld   <= 1'b0;
          r_mode  <= 1'b0;
          r_len   <= '0;
          r_flush <= 1'b0;
        end else begin
          r_a     <= io_bus.a_in;
          r_b     <= io_bus.b_in;
          r_vld   <= io_bus.valid_in;
          r_mode  <= io_bus.mode;
          r_len   <= io_bus.acc_len;
          r_flush <= io_bus.flush;
        end
      end

      assign w_s0_a     = r_a;
      assign w_s0_b     = r_b;
      assign w_s0_vld   = r_vld;
      assign w_s0_mode  = r_mode;
      assign w_s0_len   = r_len;
      assign w_s0_flush = r_flush;
    end else begin : g_in_wire
      assign w_s0_a     = io_bus.a_in;
      assign w_s0_b     = io_bus.b_in;
      assign w_s0_vld   = io_bus.valid_in;
      assign w_s0_mode  = io_bus.mode;
      assign w_s0_len   = io_bus.acc_len;
      assign w_s0_flush = io_bus.flush;
    end
  endgenerate

  // Stage 1 state
  logic [WIDTH:0]      r_s1_p [NLANES];
  logic                r_s1_vld;
  logic                r_s1_mode;
  logic [ACC_BITS-1:0] r_s1_len;
  logic                r_s1_flush;

  // Stage 1: full-width lane pair sums; the carry lands in the MSB, lanes never interact.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NLANES; i++) r_s1_p[i] <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_len   <= '0;
      r_s1_flush <= 1'b0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        r_s1_p[i] <= {1'b0, w_s0_a[i*WIDTH +: WIDTH]} + {1'b0, w_s0_b[i*WIDTH +: WIDTH]};
      end
      r_s1_vld   <= w_s0_vld;
      r_s1_mode  <= w_s0_mode;
      r_s1_len   <= w_s0_len;
      r_s1_flush <= w_s0_flush;
    end
  end

  // Stage 2 state
  state_t              r_state;
  logic [OW-1:0]       r_acc [NLANES];
  logic [ACC_BITS:0]   r_cnt;
  logic [ACC_BITS-1:0] r_len;
  logic [OW-1:0]       r_sum [NLANES];
  logic [ACC_BITS:0]   r_cnt_out;
  logic                r_vld_out;

  logic [OW-1:0]       w_acc_nxt [NLANES];
  logic [ACC_BITS:0]   w_cnt_nxt;
  logic                w_close;

  // Accumulator after folding in this cycle's sample (if any), and the window-close decision.
  always_comb begin
    w_cnt_nxt = r_cnt + {{ACC_BITS{1'b0}}, r_s1_vld};
    w_close   = r_s1_flush || (r_s1_vld && (w_cnt_nxt == ({1'b0, r_len} + CNT_ONE)));
    for (int i = 0; i < NLANES; i++) begin
      w_acc_nxt[i] = r_s1_vld ? (r_acc[i] + OW'(r_s1_p[i])) : r_acc[i];
    end
  end

  // Stage 2: window FSM; opens on a sample in IDLE, emits on the N-th sample or on flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_cnt_out <= '0;
      r_vld_out <= 1'b0;
      for (int i = 0; i < NLANES; i++) begin
        r_acc[i] <= '0;
        r_sum[i] <= '0;
      end
    end else begin
      r_vld_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_s1_vld) begin
            if (!r_s1_mode || (r_s1_len == '0) || r_s1_flush) begin
              // Single-sample result: plain pair sum, zero-extended.
              for (int i = 0; i < NLANES; i++) r_sum[i] <= OW'(r_s1_p[i]);
              r_cnt_out <= CNT_ONE;
              r_vld_out <= 1'b1;
            end else begin
              // Window parameters are frozen here; later changes wait for the next window.
              for (int i = 0; i < NLANES; i++) r_acc[i] <= OW'(r_s1_p[i]);
              r_cnt   <= CNT_ONE;
              r_len   <= r_s1_len;
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_close) begin
            for (int i = 0; i < NLANES; i++) begin
              r_sum[i] <= w_acc_nxt[i];
              r_acc[i] <= '0;
            end
            r_cnt_out <= w_cnt_nxt;
            r_vld_out <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            for (int i = 0; i < NLANES; i++) r_acc[i] <= w_acc_nxt[i];
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NLANES; g++) begin : g_pack
      assign io_bus.sum_out[g*OW +: OW] = r_sum[g];
    end
  endgenerate

  assign io_bus.cnt_out   = r_cnt_out;
  assign io_bus.valid_out = r_vld_out;
  assign io_bus.busy      = (r_state == S_ACCUM);
endmodule

// File: tb/tb_simd_lane_accum.sv
// Directed bench for simd_lane_accum at NLANES=4, WIDTH=12, ACC_BITS=4, INPUT_REG=1.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Pulses and busy cycles are also counted on the falling edge.
module tb_simd_lane_accum;
  localparam int NL = 4;
  localparam int W  = 12;
  localparam int AB = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   vcount   = 0;
  int   bcount   = 0;
  int   v0;

  simd_lane_accum_if #(.NLANES(NL), .WIDTH(W), .ACC_BITS(AB)) bus ();

  simd_lane_accum #(.NLANES(NL), .WIDTH(W), .ACC_BITS(AB), .INPUT_REG(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Falling-edge counters for output pulses and busy cycles.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) vcount++;
    if (bus.busy === 1'b1) bcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [11:0] b,
                       input logic m, input logic [3:0] l, input logic f);
    bus.valid_in = v;
    bus.a_in     = {4{a}};
    bus.b_in     = {4{b}};
    bus.mode     = m;
    bus.acc_len  = l;
    bus.flush    = f;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] lanes(input logic [16:0] v);
    return {4{v}};
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);

    // Reset held 3 cycles with valid toggling and live data
    for (int i = 0; i < 3; i++) begin
      drive(i[0] == 1'b0, 12'hABC, 12'h123, 1'b0, 4'd0, 1'b0);
      tick();
    end
    check("rst_sum",   {60'd0, bus.sum_out}, 128'd0);
    check("rst_cnt",   {123'd0, bus.cnt_out}, 128'd0);
    check("rst_valid", {127'd0, bus.valid_out}, 128'd0);
    check("rst_busy",  {127'd0, bus.busy}, 128'd0);
    drive(1'b0, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("rst_no_pulse", 128'(vcount), 128'd0);

    // Pair mode: two back-to-back samples
    v0 = vcount;
    drive(1'b1, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);
    bus.a_in = {12'h000, 12'h001, 12'h800, 12'hFFF};
    bus.b_in = {12'h000, 12'h002, 12'h800, 12'hFFF};
    tick();
    drive(1'b1, 12'h001, 12'h002, 1'b0, 4'd0, 1'b0);
    tick();
    drive(1'b0, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);
    tick();
    check("pair1_valid", {127'd0, bus.valid_out}, 128'd1);
    check("pair1_sum",   {60'd0, bus.sum_out}, {60'd0, 17'h00000, 17'h00003, 17'h01000, 17'h01FFE});
    check("pair1_cnt",   {123'd0, bus.cnt_out}, 128'd1);
    tick();
    check("pair2_valid", {127'd0, bus.valid_out}, 128'd1);
    check("pair2_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'd3)});
    tick();
    check("pair_valid_drop", {127'd0, bus.valid_out}, 128'd0);
    check("pair_hold_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'd3)});
    check("pair_pulses",     128'(vcount - v0), 128'd2);

    // Full 16-sample window of maximum operands
    v0 = vcount;
    bcount = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 12'hFFF, 12'hFFF, 1'b1, 4'd15, 1'b0);
      tick();
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd15, 1'b0);
    tick(); tick();
    check("full_valid", {127'd0, bus.valid_out}, 128'd1);
    check("full_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'h1FFE0)});
    check("full_cnt",   {123'd0, bus.cnt_out}, 128'd16);
    tick(); tick();
    check("full_pulses", 128'(vcount - v0), 128'd1);
    check("full_busy_cycles", 128'(bcount), 128'd15);

    // Gapped window with ACC_LEN change mid-window, then abutting single-sample window
    v0 = vcount;
    for (int c = 0; c <= 10; c++) begin
      drive((c == 0) || (c == 3) || (c == 4) || (c == 9) || (c == 10),
            12'd1, 12'd2, 1'b1, (c >= 5) ? 4'd0 : 4'd3, 1'b0);
      tick();
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd0, 1'b0);
    tick();
    check("gap_valid", {127'd0, bus.valid_out}, 128'd1);
    check("gap_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'd12)});
    check("gap_cnt",   {123'd0, bus.cnt_out}, 128'd4);
    tick();
    check("gap_next_valid", {127'd0, bus.valid_out}, 128'd1);
    check("gap_next_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'd3)});
    check("gap_next_cnt",   {123'd0, bus.cnt_out}, 128'd1);
    tick();
    check("gap_pulses", 128'(vcount - v0), 128'd2);

    // Flush coincident with the 4th sample of an 8-sample window
    v0 = vcount;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'h010, 12'h010, 1'b1, 4'd7, i == 3);
      tick();
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd7, 1'b0);
    tick(); tick();
    check("flush_valid", {127'd0, bus.valid_out}, 128'd1);
    check("flush_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'h80)});
    check("flush_cnt",   {123'd0, bus.cnt_out}, 128'd4);
    tick();
    check("flush_busy_after", {127'd0, bus.busy}, 128'd0);

    // Flush alone while idle does nothing
    v0 = vcount;
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd7, 1'b1);
    tick();
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd7, 1'b0);
    tick(); tick(); tick(); tick();
    check("idle_flush_pulses", 128'(vcount - v0), 128'd0);
    check("idle_flush_busy",   {127'd0, bus.busy}, 128'd0);

    // Flush alone after a gap emits the partial sum
    v0 = vcount;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 12'd1, 12'd1, 1'b1, 4'd7, 1'b0);
      tick();
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd7, 1'b0);
    tick(); tick(); tick();
    check("gap_flush_busy", {127'd0, bus.busy}, 128'd1);
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd7, 1'b1);
    tick();
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd7, 1'b0);
    tick(); tick();
    check("lone_flush_valid", {127'd0, bus.valid_out}, 128'd1);
    check("lone_flush_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'd4)});
    check("lone_flush_cnt",   {123'd0, bus.cnt_out}, 128'd2);

    // Reset in the middle of a 16-sample window
    tick();
    v0 = vcount;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'd1, 12'd1, 1'b1, 4'd15, 1'b0);
      tick();
    end
    drive(1'b0, 12'h0, 12'h0, 1'b1, 4'd15, 1'b0);
    tick(); tick();
    check("mid_busy_before", {127'd0, bus.busy}, 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_rst_pulses", 128'(vcount - v0), 128'd0);
    check("mid_rst_busy",   {127'd0, bus.busy}, 128'd0);
    check("mid_rst_sum",    {60'd0, bus.sum_out}, 128'd0);

    // Fresh 2-sample window after reset
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 12'd1, 12'd1, 1'b1, 4'd1, 1'b0);
      tick();
    end
    drive(1'b0, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);
    tick(); tick();
    check("fresh_valid", {127'd0, bus.valid_out}, 128'd1);
    check("fresh_sum",   {60'd0, bus.sum_out}, {60'd0, lanes(17'd4)});
    check("fresh_cnt",   {123'd0, bus.cnt_out}, 128'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
